pmod_input_conditioner: RTL and testbench
=========================================

// Module: pmod_input_conditioner
// PURPOSE
//  Front-end stage for the PMOD switch/button inputs, upstream of the LED adder logic.
//  Each raw asynchronous pin passes through a 2-FF synchroniser and then a per-channel debounce counter.
//  Outputs are a clean level per channel plus one-cycle rise/fall pulses.
//  Downstream combinational logic consumes stable_out in place of the raw PMOD pins.
// PARAMETERS
//  N               4       number of input channels (1..8)
//  DEBOUNCE_CYCLES 120000  consecutive cycles a new level must persist (>=1; 10 ms @ 12 MHz)
//  CW              $clog2(DEBOUNCE_CYCLES+1)  counter width, derived; not overridden
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst         in   1   synchronous, active-high reset
//  pmod_in     in   N   raw asynchronous pins, bit i = channel i
//  stable_out  out  N   debounced level per channel
//  rise_pulse  out  N   1-cycle strobe, channel's stable_out just went 0->1
//  fall_pulse  out  N   1-cycle strobe, channel's stable_out just went 1->0
//  any_change  out  1   OR of all rise_pulse|fall_pulse bits
// BEHAVIOUR
//  - Reset: sync1, sync2, stable_out, counters, rise_pulse, fall_pulse and any_change all 0.
//    rst has priority over every other update.
//  - Sync: sync1 <= pmod_in; sync2 <= sync1. sync1 feeds only sync2.
//  - Per channel i, per edge:
//      * sync2[i] == stable_out[i]: cnt[i] <= 0.
//      * mismatch and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
//      * mismatch and cnt[i] == DEBOUNCE_CYCLES-1: stable_out[i] <= sync2[i]; cnt[i] <= 0.
//  - Latency: pin change sampled at edge k and held -> stable_out changes after edge k+DEBOUNCE_CYCLES+1.
//  - Glitch rejection: any return to the old level before the count completes clears cnt[i].
//    A fresh full count is then required. Pulses shorter than DEBOUNCE_CYCLES never propagate.
//  - Pulses are registered on the same edge that updates stable_out.
//      * rise_pulse[i] is high for exactly the following cycle on a 0->1 update.
//      * fall_pulse[i] is high for exactly the following cycle on a 1->0 update.
//      * Otherwise both are 0. rise and fall are never both high for one channel.
//  - Channels are fully independent. Simultaneous transitions on several channels give simultaneous pulses.
//    any_change is registered alongside the pulses.
//  - Counter saturation cannot occur: cnt never exceeds DEBOUNCE_CYCLES-1.
//  - Reset mid-count: all progress discarded.
//    A pin held high through reset release produces a rise_pulse DEBOUNCE_CYCLES+1 edges after the first non-reset edge.
//  - DEBOUNCE_CYCLES==1: cnt is unused, and stable_out follows sync2 one edge later.
// TESTING (bench uses N=4, DEBOUNCE_CYCLES=4)
//  1. rst high 3 cycles, pmod_in=4'hF
//     -> stable_out=0, pulses=0 during reset.
//     -> After release, stable_out=4'hF and rise_pulse=4'hF (1 cycle) 5 edges after the first non-reset edge.
//  2. pmod_in[0] 0->1 held
//     -> stable_out[0]=1 exactly 5 edges after the sampling edge.
//     -> rise_pulse=4'b0001 for one cycle, any_change=1 that cycle only.
//  3. pmod_in[1] high for 3 cycles then low (glitch)
//     -> stable_out[1] stays 0, no pulse.
//  4. pmod_in[2] bounce 1,0,1,1,1,1,1
//     -> counter clears on the 0; stable_out[2]=1 only after 4 consecutive mismatching sync2 cycles.
//  5. pmod_in 4'b0011->4'b1100 in one cycle (from stable 4'b0011)
//     -> same edge: stable_out=4'b1100, rise_pulse=4'b1100, fall_pulse=4'b0011.
//  6. rst asserted at cnt=2 on channel 3
//     -> stable_out[3]=0 and cnt cleared; full 4-cycle count required after release.

Source files
------------

// File: rtl/pmod_input_conditioner.sv
// PMOD input front end: two-flop synchroniser, per-channel debounce counter,
// and registered rise/fall strobes for every channel.
module pmod_input_conditioner #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] pmod_in,
    output logic [N-1:0] stable_out,
    output logic [N-1:0] rise_pulse,
    output logic [N-1:0] fall_pulse,
    output logic         any_change
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]  sync1_q,  sync1_d;
    logic [N-1:0]  sync2_q,  sync2_d;
    logic [N-1:0]  stable_q, stable_d;
    logic [N-1:0]  rise_q,   rise_d;
    logic [N-1:0]  fall_q,   fall_d;
    logic          any_q,    any_d;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    // A channel only commits a new level once sync2 has disagreed with it for
    // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
    always_comb begin
        sync1_d  = pmod_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    rise_d[i]   = sync2_q[i];
                    fall_d[i]   = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            any_q    <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            any_q    <= any_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stable_out = stable_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_change = any_q;

endmodule

// File: tb/tb_pmod_input_conditioner.sv
// Bench for pmod_input_conditioner with N=4, DEBOUNCE_CYCLES=4: directed vector
// table, multi-cycle corner sequences, and randomized pins against a window model.
module tb_pmod_input_conditioner;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] pmod_in;
    logic [N-1:0] stable_out;
    logic [N-1:0] rise_pulse;
    logic [N-1:0] fall_pulse;
    logic         any_change;

    int checks = 0;
    int errors = 0;

    pmod_input_conditioner #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .pmod_in    (pmod_in),
        .stable_out (stable_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_change (any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level is adopted once the last D synchronised samples
    // all disagree with the current level.
    logic [N-1:0] m_s1, m_s2, m_stable, m_rise, m_fall;
    logic         m_any;
    logic [N-1:0] hist[$];

    typedef struct {
        logic         rst;
        logic [N-1:0] pmod;
        logic [N-1:0] stable;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic         any;
    } vec_t;

    vec_t vecs[$];

    // Drive one cycle of inputs, advance the model, and wait until just after the edge.
    task automatic applyStimulus(input logic rst_v, input logic [N-1:0] pmod_v);
        logic [N-1:0] nxt;
        logic [N-1:0] h;
        logic         all_diff;
        rst     = rst_v;
        pmod_in = pmod_v;
        if (rst_v) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0;
            m_rise = '0; m_fall = '0; m_any = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            nxt = m_stable;
            for (int i = 0; i < N; i++) begin
                if (hist.size() == D) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < hist.size(); k++) begin
                        h = hist[k];
                        if (h[i] == m_stable[i]) all_diff = 1'b0;
                    end
                    if (all_diff) nxt[i] = ~m_stable[i];
                end
            end
            m_rise   = nxt & ~m_stable;
            m_fall   = ~nxt & m_stable;
            m_any    = |(m_rise | m_fall);
            m_stable = nxt;
            m_s2     = m_s1;
            m_s1     = pmod_v;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".stable"}, stable_out, m_stable);
        checkVal({tag, ".rise"},   rise_pulse, m_rise);
        checkVal({tag, ".fall"},   fall_pulse, m_fall);
        checkVal({tag, ".any"},    {3'b000, any_change}, {3'b000, m_any});
    endtask

    task automatic step(input string tag, input logic rst_v, input logic [N-1:0] pmod_v);
        applyStimulus(rst_v, pmod_v);
        checkOutput(tag);
    endtask

    initial begin
        logic [N-1:0] pv;
        int           hold;
        rst     = 1'b1;
        pmod_in = '0;
        m_s1 = '0; m_s2 = '0; m_stable = '0;
        m_rise = '0; m_fall = '0; m_any = 1'b0;

        // Reset with all pins high, release, then a clean single-channel rise.
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0});
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1});
        vecs.push_back('{1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0});
        for (int i = 0; i < 2; i++) vecs.push_back('{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
        for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0});
        vecs.push_back('{1'b0, 4'h1, 4'h1, 4'h1, 4'h0, 1'b1});
        vecs.push_back('{1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0});

        for (int v = 0; v < vecs.size(); v++) begin
            applyStimulus(vecs[v].rst, vecs[v].pmod);
            checkVal($sformatf("vec%0d.stable", v), stable_out, vecs[v].stable);
            checkVal($sformatf("vec%0d.rise", v),   rise_pulse, vecs[v].rise);
            checkVal($sformatf("vec%0d.fall", v),   fall_pulse, vecs[v].fall);
            checkVal($sformatf("vec%0d.any", v),    {3'b000, any_change}, {3'b000, vecs[v].any});
            checkOutput($sformatf("vec%0d.model", v));
        end

        // Glitch on channel 1 shorter than the debounce window.
        for (int j = 0; j < 11; j++) begin
            step("glitch", 1'b0, (j < 3) ? 4'b0011 : 4'b0001);
            checkVal("glitch.stable", stable_out, 4'b0001);
            checkVal("glitch.rise",   rise_pulse, 4'b0000);
        end

        // Bouncing channel 2: the low sample restarts the count.
        for (int j = 0; j < 9; j++) begin
            step("bounce", 1'b0, (j == 1) ? 4'b0001 : 4'b0101);
            checkVal("bounce.stable2", {3'b000, stable_out[2]}, {3'b000, logic'(j >= 7)});
            checkVal("bounce.rise2",   {3'b000, rise_pulse[2]}, {3'b000, logic'(j == 7)});
        end

        // Swap all four channels in one cycle.
        for (int j = 0; j < 8; j++) step("swap.pre", 1'b0, 4'b0011);
        checkVal("swap.pre.stable", stable_out, 4'b0011);
        for (int j = 0; j < 7; j++) begin
            step("swap", 1'b0, 4'b1100);
            if (j == 4) checkVal("swap.before", stable_out, 4'b0011);
            if (j == 5) begin
                checkVal("swap.stable", stable_out, 4'b1100);
                checkVal("swap.rise",   rise_pulse, 4'b1100);
                checkVal("swap.fall",   fall_pulse, 4'b0011);
                checkVal("swap.any",    {3'b000, any_change}, 4'b0001);
            end
        end

        // Reset in the middle of a channel 3 count discards the progress.
        for (int j = 0; j < 2; j++) step("midrst.clr", 1'b1, 4'b0000);
        for (int j = 0; j < 2; j++) step("midrst.idle", 1'b0, 4'b0000);
        for (int j = 0; j < 4; j++) step("midrst.count", 1'b0, 4'b1000);
        for (int j = 0; j < 2; j++) begin
            step("midrst.rst", 1'b1, 4'b1000);
            checkVal("midrst.rst.stable", stable_out, 4'b0000);
        end
        for (int j = 0; j < 7; j++) begin
            step("midrst.rel", 1'b0, 4'b1000);
            checkVal("midrst.stable3", {3'b000, stable_out[3]}, {3'b000, logic'(j >= 5)});
            checkVal("midrst.rise3",   {3'b000, rise_pulse[3]}, {3'b000, logic'(j == 5)});
        end

        // Randomized pins held for random lengths, with occasional resets.
        pv   = '0;
        hold = 0;
        for (int c = 0; c < 800; c++) begin
            if (hold == 0) begin
                pv   = N'($urandom_range(0, 15));
                hold = $urandom_range(1, 7);
            end
            hold--;
            step("random", ($urandom_range(0, 99) == 0), pv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
